// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock show-ahead FIFO.
// Provides:
//   DEF_AWIDTH / DEF_DWIDTH  default address and data widths
//   fifo_depth()             depth for a given address width (2**aw)
//   fifo_status_t            status bundle seen by producer and consumer
package fifo_pkg;

    localparam int DEF_AWIDTH = 4;
    localparam int DEF_DWIDTH = 8;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // usedw is one bit wider than the address so a full FIFO is representable.
    typedef struct packed {
        logic                  empty;
        logic                  full;
        logic                  almost_empty;
        logic                  almost_full;
        logic [DEF_AWIDTH:0]   usedw;
    } fifo_status_t;

endpackage

// File: rtl/fifo_wrap_cnt.sv
// AWIDTH-bit pointer register with increment enable.
// Wraps naturally modulo 2**AWIDTH.
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset (pointer to 0)
//   inc_i    advance the pointer by one on the next edge
//   cnt_o    current pointer value
module fifo_wrap_cnt
    import fifo_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              inc_i,
    output logic [AWIDTH-1:0] cnt_o
);

    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + ONE;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a single-clock show-ahead FIFO of depth
// 2**AWIDTH, driving a dual-port RAM with synchronous write / async read.
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   wrreq_i, rdreq_i      producer write / consumer read requests
//   wren_o                RAM write enable (combinational: wrreq_i & ~full_o)
//   wrpntr_o, rdpntr_o    RAM write / read addresses
//   usedw_o               stored word count, 0..2**AWIDTH
//   empty_o, full_o       registered status flags
//   almost_full_o         usedw_o >= ALMOST_FULL_VALUE
//   almost_empty_o        usedw_o <  ALMOST_EMPTY_VALUE
//   ovf_o, udf_o          one-cycle pulses for rejected write / read
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AWIDTH             = DEF_AWIDTH,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic              wren_o,
    output logic [AWIDTH-1:0] wrpntr_o,
    output logic [AWIDTH-1:0] rdpntr_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam int              DEPTH   = fifo_depth(AWIDTH);
    localparam logic [AWIDTH:0] DEPTH_V = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_V    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_V    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);
    localparam logic            AE_RST  = (ALMOST_EMPTY_VALUE > 0);
    localparam logic            AF_RST  = (ALMOST_FULL_VALUE == 0);

    if (AWIDTH < 1 || ALMOST_EMPTY_VALUE < 0 ||
        ALMOST_EMPTY_VALUE > ALMOST_FULL_VALUE ||
        ALMOST_FULL_VALUE > DEPTH) begin : g_param_check
        $error("fifo_ctrl: illegal AWIDTH / ALMOST_*_VALUE combination");
    end

    logic              wr_ok;
    logic              rd_ok;
    logic [AWIDTH:0]   usedw_nxt;

    assign wr_ok  = wrreq_i & ~full_o;
    assign rd_ok  = rdreq_i & ~empty_o;
    assign wren_o = wr_ok;

    // A simultaneous accepted read and write leaves the count unchanged.
    always_comb begin
        usedw_nxt = usedw_o;
        if (wr_ok && !rd_ok) begin
            usedw_nxt = usedw_o + ONE;
        end else if (rd_ok && !wr_ok) begin
            usedw_nxt = usedw_o - ONE;
        end
    end

    // Flags are registered from the next count so they line up with usedw_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            usedw_o        <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= AF_RST;
            almost_empty_o <= AE_RST;
            ovf_o          <= 1'b0;
            udf_o          <= 1'b0;
        end else begin
            usedw_o        <= usedw_nxt;
            empty_o        <= (usedw_nxt == '0);
            full_o         <= (usedw_nxt == DEPTH_V);
            almost_full_o  <= (usedw_nxt >= AF_V);
            almost_empty_o <= (usedw_nxt < AE_V);
            ovf_o          <= wrreq_i & full_o;
            udf_o          <= rdreq_i & empty_o;
        end
    end

    fifo_wrap_cnt #(.AWIDTH(AWIDTH)) u_wr_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (wr_ok),
        .cnt_o   (wrpntr_o)
    );

    fifo_wrap_cnt #(.AWIDTH(AWIDTH)) u_rd_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (rd_ok),
        .cnt_o   (rdpntr_o)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          wrreq_i;
    logic          rdreq_i;
    logic          wren_o;
    logic [AW-1:0] wrpntr_o;
    logic [AW-1:0] rdpntr_o;
    logic [AW:0]   usedw_o;
    logic          empty_o;
    logic          full_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          ovf_o;
    logic          udf_o;

    logic [DEF_DWIDTH-1:0] wdata;
    logic [DEF_DWIDTH-1:0] mem [DEPTH];

    int tests  = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fifo_ctrl #(
        .AWIDTH             (AW),
        .ALMOST_FULL_VALUE  (AF),
        .ALMOST_EMPTY_VALUE (AE)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .wrreq_i        (wrreq_i),
        .rdreq_i        (rdreq_i),
        .wren_o         (wren_o),
        .wrpntr_o       (wrpntr_o),
        .rdpntr_o       (rdpntr_o),
        .usedw_o        (usedw_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .ovf_o          (ovf_o),
        .udf_o          (udf_o)
    );

    // RAM stand-in: sync write, async read.
    always @(posedge clk_i) begin
        if (wren_o) mem[wrpntr_o] <= wdata;
    end

    typedef struct {
        bit           wren;
        fifo_status_t st;
        bit           ovf;
        bit           udf;
        int           wp;
        int           rp;
        bit           chk;
        int           data;
    } rec_t;

    rec_t exp_q[$];

    // Reference model: a queue of stored words plus running totals.
    int  m_q[$];
    int  m_wr_total = 0;
    int  m_rd_total = 0;
    bit  m_ovf = 0;
    bit  m_udf = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit wr, input bit rd);
        rec_t r;
        int   n;
        bit   wr_ok, rd_ok;
        @(posedge clk_i);
        #1;
        rst_n_i = rst_n;
        wrreq_i = wr;
        rdreq_i = rd;
        wdata   = DEF_DWIDTH'($urandom);
        if (!rst_n) begin
            m_q.delete();
            m_wr_total = 0;
            m_rd_total = 0;
            m_ovf = 0;
            m_udf = 0;
        end
        n = m_q.size();
        r.st.empty        = (n == 0);
        r.st.full         = (n == DEPTH);
        r.st.almost_empty = (n < AE);
        r.st.almost_full  = (n >= AF);
        r.st.usedw        = (AW+1)'(n);
        r.ovf  = m_ovf;
        r.udf  = m_udf;
        r.wp   = m_wr_total % DEPTH;
        r.rp   = m_rd_total % DEPTH;
        r.wren = wr && (n != DEPTH);
        r.chk  = 0;
        r.data = 0;
        if (rst_n) begin
            wr_ok = wr && (n != DEPTH);
            rd_ok = rd && (n != 0);
            if (rd_ok) begin
                r.chk  = 1;
                r.data = m_q[0];
            end
            m_ovf = wr && (n == DEPTH);
            m_udf = rd && (n == 0);
            if (rd_ok) begin
                void'(m_q.pop_front());
                m_rd_total++;
            end
            if (wr_ok) begin
                m_q.push_back(int'(wdata));
                m_wr_total++;
            end
        end
        exp_q.push_back(r);
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            rec_t r;
            r = exp_q.pop_front();
            check("wren",         int'(wren_o),         int'(r.wren));
            check("usedw",        int'(usedw_o),        int'(r.st.usedw));
            check("empty",        int'(empty_o),        int'(r.st.empty));
            check("full",         int'(full_o),         int'(r.st.full));
            check("almost_empty", int'(almost_empty_o), int'(r.st.almost_empty));
            check("almost_full",  int'(almost_full_o),  int'(r.st.almost_full));
            check("ovf",          int'(ovf_o),          int'(r.ovf));
            check("udf",          int'(udf_o),          int'(r.udf));
            check("wrpntr",       int'(wrpntr_o),       r.wp);
            check("rdpntr",       int'(rdpntr_o),       r.rp);
            check("ptr_diff",     int'(AW'(wrpntr_o - rdpntr_o)), int'(usedw_o[AW-1:0]));
            if (r.chk) check("rd_data", int'(mem[rdpntr_o]), r.data);
        end
    end

    initial begin
        int pw, pr;
        rst_n_i = 1'b0;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        wdata   = '0;

        // Reset with random request activity.
        for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom), 1'($urandom));
        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        // Drain completely, then one rejected read.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // Simultaneous requests while empty.
        step(1'b1, 1'b1, 1'b1);
        // Refill to full, simultaneous requests while full.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        // Down to 8 words, then a long simultaneous burst to wrap pointers.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1);
        // Reset in the middle of the burst.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        // Randomized traffic with drifting bias and occasional reset.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                pw = int'($urandom_range(10, 90));
                pr = 100 - pw;
            end
            step(($urandom_range(0, 199) != 0),
                 (int'($urandom_range(0, 99)) < pw),
                 (int'($urandom_range(0, 99)) < pr));
        end
        step(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for a single-clock, show-ahead FIFO of depth 2**AWIDTH.
- Sits directly upstream of the team's dual-port RAM (sync write, async read). Drives its write enable, write pointer and read pointer.
- Reports occupancy and status flags to the producer and consumer.
- The FIFO top level instantiates this block and the RAM.

Parameters:
- AWIDTH, 4, address width; FIFO depth = 2**AWIDTH.
- ALMOST_FULL_VALUE, 12, almost_full_o asserts when usedw_o >= this value.
- ALMOST_EMPTY_VALUE, 4, almost_empty_o asserts when usedw_o < this value.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- wrreq_i  in  1  producer write request.
- rdreq_i  in  1  consumer read request; consumes the word currently on the RAM output.
- wren_o  out  1  RAM write enable.
- wrpntr_o  out  AWIDTH  RAM write address.
- rdpntr_o  out  AWIDTH  RAM read address.
- usedw_o  out  AWIDTH+1  number of stored words, 0..2**AWIDTH.
- empty_o  out  1  no valid data.
- full_o  out  1  2**AWIDTH words stored.
- almost_full_o  out  1  see parameters.
- almost_empty_o  out  1  see parameters.
- ovf_o  out  1  one-cycle pulse: write request rejected because full.
- udf_o  out  1  one-cycle pulse: read request rejected because empty.

Behaviour:
- Reset (rst_n_i low, async assert, release synchronised externally):
  - wrpntr_o, rdpntr_o, usedw_o = 0.
  - empty_o = 1, full_o = 0.
  - almost_empty_o = (0 < ALMOST_EMPTY_VALUE).
  - almost_full_o = (ALMOST_FULL_VALUE == 0).
  - ovf_o, udf_o = 0.
- Write accept: wr_ok = wrreq_i & ~full_o.
  - wren_o = wr_ok, combinational; it is the only combinational output.
- Read accept: rd_ok = rdreq_i & ~empty_o.
- On each rising edge:
  - wr_ok: wrpntr_o += 1, modulo 2**AWIDTH, natural wrap.
  - rd_ok: rdpntr_o += 1, natural wrap.
  - usedw_o: +1 if wr_ok only; -1 if rd_ok only; unchanged if both or neither.
  - All flags are registered and computed from the next usedw value:
    - empty_o = (next == 0).
    - full_o = (next == 2**AWIDTH).
    - almost_full_o = (next >= ALMOST_FULL_VALUE).
    - almost_empty_o = (next < ALMOST_EMPTY_VALUE).
  - ovf_o <= wrreq_i & full_o.
  - udf_o <= rdreq_i & empty_o.
- Show-ahead: while empty_o = 0, the RAM output at rdpntr_o holds the oldest word; no read latency.
- Write-to-read latency: a word written at edge N is visible, with empty_o deasserted, after edge N.
- Simultaneous requests:
  - Not empty and not full: both accepted; usedw unchanged; both pointers advance.
  - Empty: write accepted, read rejected; udf_o pulses; usedw becomes 1.
  - Full: read accepted, write rejected; ovf_o pulses; usedw becomes 2**AWIDTH-1.
- Rejected requests never move pointers or change usedw.
- Invariant: wrpntr_o - rdpntr_o (mod 2**AWIDTH) == usedw_o[AWIDTH-1:0]; full_o implies the pointers are equal.
- Reset mid-operation: all state returns to reset values immediately; RAM contents are not cleared and are treated as invalid.
- Parameter legality, checked by elaboration assertion:
  - 0 <= ALMOST_EMPTY_VALUE <= ALMOST_FULL_VALUE <= 2**AWIDTH.
  - AWIDTH >= 1.

Decomposition:
- Shared package fifo_pkg holds:
  - the default AWIDTH and DWIDTH constants;
  - the function computing DEPTH = 2**AWIDTH;
  - a typedef for the status bundle {empty, full, almost_empty, almost_full, usedw}, for reuse by the FIFO top and the bench.
- One natural sub-module: fifo_wrap_cnt, an AWIDTH-bit pointer register with increment enable and async active-low reset, instantiated twice.
- Usedw and flag logic stay in fifo_ctrl.

Test Plan (AWIDTH=4, AF=12, AE=4):
- Reset with random wrreq/rdreq toggling -> all outputs at reset values (empty=1, almost_empty=1, usedw=0); wren_o = wrreq_i.
- 16 consecutive writes -> usedw steps 1..16; almost_empty drops after the 4th write; almost_full rises after the 12th; full after the 16th; wrpntr wraps to 0.
- Full plus one extra write -> wren_o=0, ovf_o pulses one cycle, pointers unchanged. Then 16 reads -> rdpntr 0..15 then 0, empty=1 after the last read, data order matches.
- Empty with wrreq and rdreq together -> udf_o pulses, usedw=1, empty_o=0 next cycle, rdpntr unchanged.
- Full with wrreq and rdreq together -> usedw=15, full_o=0, ovf_o pulses, rdpntr+1, wrpntr unchanged.
- 8 words stored, 40 cycles of simultaneous rd/wr to force pointer wrap -> usedw stays 8, pointer-difference invariant holds; rst_n_i asserted mid-burst -> immediate reset values.
